icebus_responder: RTL
=====================

// Module: icebus_responder
// PURPOSE
//  Motor-board end of the ICEbus UART link; the FPGA-side bus controller is the initiator.
//  Receives 8-byte command frames, accepts those carrying its ID, updates setpoint/command
//  outputs, then answers with an 8-byte status frame containing status and current_average.
//  Drives an RS485 driver enable for half-duplex operation.
// PARAMETERS
//  CLKS_PER_BIT  50   clk cycles per UART bit (50 MHz / 1 Mbaud); >= 8
//  MY_ID         8'h01  bus address this responder answers to
//  TURNAROUND    2    idle bit times between last RX stop bit and first TX start bit
//  TIMEOUT_BITS  20   max inter-byte gap, in bit times, before the frame is dropped
// PORTS
//  clk_clk          in   1   system clock
//  reset_reset_n    in   1   asynchronous active-low reset
//  rx               in   1   UART serial in, idle high (async; 2-flop synchronised)
//  tx               out  1   UART serial out, 8N1, LSB first, idle high
//  tx_en            out  1   RS485 driver enable
//  status           in   8   status byte returned in the response
//  current_average  in   32  current value returned in the response
//  setpoint         out  32  last accepted setpoint
//  command          out  8   last accepted command byte
//  cmd_valid        out  1   1-cycle pulse when setpoint/command update
//  frame_error      out  1   1-cycle pulse on bad stop bit, bad checksum or timeout
// BEHAVIOUR
//  Reset: tx=1, tx_en=0, setpoint=0, command=0, cmd_valid=0, frame_error=0, FSM=IDLE.
//  UART RX: falling edge on synced rx starts a byte; sample at mid-bit (CLKS_PER_BIT/2).
//   Start bit low at mid-sample is required, else treat as glitch and return to idle.
//   Stop bit sampled low -> frame_error pulse, parser to IDLE.
//  Command frame (bytes in order): A5, ID, CMD, D3, D2, D1, D0, CHK.
//   CHK = XOR of ID..D0. setpoint = {D3,D2,D1,D0}.
//  Parser FSM: IDLE -> (byte==A5) HDR -> ID -> CMD -> DATA(4) -> CHK.
//   Bytes other than A5 in IDLE are ignored silently.
//   Bad CHK -> frame_error pulse, IDLE, no response.
//   Good CHK with ID!=MY_ID -> IDLE silently; outputs are unchanged.
//   Good CHK with ID==MY_ID -> on the cycle after the stop-bit sample:
//     setpoint and command are registered and cmd_valid pulses.
//     status and current_average are sampled into the TX buffer in that same cycle.
//     FSM -> TURN.
//  Timeout: in any state past IDLE, gap > TIMEOUT_BITS*CLKS_PER_BIT cycles between stop bit
//   and next start bit -> frame_error pulse, IDLE.
//  TURN: wait TURNAROUND*CLKS_PER_BIT cycles with tx=1; tx_en rises on the last cycle of TURN.
//  SEND: response frame is 5A, MY_ID, STATUS, C3, C2, C1, C0, CHK.
//   C3..C0 are the current bytes, MSB first. CHK = XOR of MY_ID..C0.
//   Bytes go back to back, 10 bit times each.
//   tx_en falls 1 cycle after the end of the last stop bit; FSM -> IDLE.
//  Half duplex: the RX byte engine and parser are held idle while tx_en=1, so the echo
//   is ignored. The receiver re-arms only on a falling edge seen after tx_en=0.
//  Reset mid-frame (either direction): outputs return to reset values immediately;
//   a partial frame is never completed.
//  Bit and cycle counters saturate or clear at boundaries; none of them wraps while in use.
// TESTING
//  1. A5 01 10 00 00 03 E8 FA from initiator model.
//     -> cmd_valid 1 cycle; setpoint=0x000003E8; command=0x10.
//     -> after 2 bit times: 5A 01 <status> <cur 4B> <xor> on tx; tx_en frames exactly those 80 bits.
//  2. Same frame with ID=02 (CHK recomputed to F9).
//     -> no cmd_valid, tx stays 1, tx_en stays 0, setpoint unchanged.
//  3. Frame 1 with CHK=00.
//     -> frame_error pulse; no response; setpoint unchanged.
//  4. First 4 bytes sent, then a 30-bit-time gap, then a full valid frame.
//     -> frame_error pulse on timeout; the subsequent frame is accepted normally.
//  5. Stop bit forced low on byte 3.
//     -> frame_error pulse; parser resyncs on the next A5.
//  6. reset_reset_n asserted during response byte 4.
//     -> tx=1 and tx_en=0 at once; after release, a valid frame receives a full response.

Source files
------------

// File: rtl/icebus_responder.sv
// ICEbus motor-board responder: 8N1 UART receiver, command-frame parser and
// half-duplex status-frame transmitter driving the RS485 enable.
module icebus_responder #(
   parameter int         CLKS_PER_BIT = 50,
   parameter logic [7:0] MY_ID        = 8'h01,
   parameter int         TURNAROUND   = 2,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        rx,
   output logic        tx,
   output logic        tx_en,
   input  logic [7:0]  status,
   input  logic [31:0] current_average,
   output logic [31:0] setpoint,
   output logic [7:0]  command,
   output logic        cmd_valid,
   output logic        frame_error
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam int            TURN_CYC  = TURNAROUND * CLKS_PER_BIT;
   localparam int            TW        = $clog2(TURN_CYC + 1);
   localparam logic [TW-1:0] TURN_EN   = TW'(TURN_CYC - 2);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
   localparam int            GAP_CYC   = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int            GW        = $clog2(GAP_CYC + 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYC);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_CMD, ST_DATA, ST_CHK, ST_TURN, ST_SEND, ST_HOLD
   } state_t;

   logic          rx_meta, rx_s, rx_d;
   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_tick, rx_hold, byte_done, stop_err;

   state_t        state, state_n;
   logic [7:0]    id_q, cmd_q, chk_q;
   logic [31:0]   data_q;
   logic [1:0]    data_cnt;
   logic [GW-1:0] gap_cnt;
   logic          in_frame, timeout, accept, frame_err_n;
   logic [7:0]    resp_chk;

   logic [TW-1:0] turn_cnt;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [2:0]    tx_byte;
   logic [63:0]   tx_buf;
   logic [9:0]    tx_shift;
   logic          tx_tick;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) {rx_meta, rx_s, rx_d} <= 3'b111;
      else                {rx_meta, rx_s, rx_d} <= {rx, rx_meta, rx_s};
   end

   // ---------------- UART receive byte engine ----------------
   assign rx_tick   = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
   assign byte_done = (rx_state == RX_STOP) && rx_tick && rx_s;
   assign stop_err  = (rx_state == RX_STOP) && rx_tick && !rx_s;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rx_state_n = rx_state;
      if (rx_hold) begin
         rx_state_n = RX_IDLE;
      end else begin
         case (rx_state)
            RX_IDLE:  if (rx_d && !rx_s) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_n;
         if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
         else                                rx_cnt <= rx_cnt + CW'(1);
         if (rx_state != RX_DATA) begin
            rx_bit <= '0;
         end else if (rx_tick) begin
            rx_bit   <= rx_bit + 3'd1;
            rx_shift <= {rx_s, rx_shift[7:1]};
         end
      end
   end

   // ---------------- Frame parser / sequencer ----------------
   assign in_frame = state inside {ST_HDR, ST_CMD, ST_DATA, ST_CHK};
   assign timeout  = in_frame && (gap_cnt == GAP_MAX);
   // The receiver is deaf while we own the bus, so our own echo never parses.
   assign rx_hold  = (state inside {ST_TURN, ST_SEND, ST_HOLD}) || tx_en;
   assign resp_chk = MY_ID ^ status ^ current_average[31:24] ^ current_average[23:16]
                   ^ current_average[15:8] ^ current_average[7:0];

   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         ST_IDLE: if (byte_done && rx_shift == 8'hA5) state_n = ST_HDR;
         ST_HDR:  if (byte_done) state_n = ST_CMD;
         ST_CMD:  if (byte_done) state_n = ST_DATA;
         ST_DATA: if (byte_done && data_cnt == 2'd3) state_n = ST_CHK;
         ST_CHK: begin
            if (byte_done) begin
               if (rx_shift != chk_q) begin
                  frame_err_n = 1'b1;
                  state_n     = ST_IDLE;
               end else if (id_q == MY_ID) begin
                  accept  = 1'b1;
                  state_n = ST_TURN;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_TURN: if (turn_cnt == TURN_LAST) state_n = ST_SEND;
         ST_SEND: if (tx_tick && tx_bit == 4'd9 && tx_byte == 3'd7) state_n = ST_HOLD;
         ST_HOLD: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (stop_err || timeout) begin
         frame_err_n = 1'b1;
         state_n     = ST_IDLE;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state       <= ST_IDLE;
         cmd_valid   <= 1'b0;
         frame_error <= 1'b0;
         setpoint    <= '0;
         command     <= '0;
         id_q        <= '0;
         cmd_q       <= '0;
         chk_q       <= '0;
         data_q      <= '0;
         data_cnt    <= '0;
         gap_cnt     <= '0;
      end else begin
         state       <= state_n;
         cmd_valid   <= accept;
         frame_error <= frame_err_n;
         if (byte_done) begin
            case (state)
               ST_HDR: begin
                  id_q  <= rx_shift;
                  chk_q <= rx_shift;
               end
               ST_CMD: begin
                  cmd_q <= rx_shift;
                  chk_q <= chk_q ^ rx_shift;
               end
               ST_DATA: begin
                  data_q <= {data_q[23:0], rx_shift};
                  chk_q  <= chk_q ^ rx_shift;
               end
               default: ;
            endcase
         end
         if (state != ST_DATA) data_cnt <= '0;
         else if (byte_done)   data_cnt <= data_cnt + 2'd1;
         // Inter-byte gap: counts only while a frame is open and the line is idle.
         if (!in_frame || rx_state != RX_IDLE) gap_cnt <= '0;
         else if (gap_cnt != GAP_MAX)          gap_cnt <= gap_cnt + GW'(1);
         if (accept) begin
            setpoint <= data_q;
            command  <= cmd_q;
         end
      end
   end

   // ---------------- Response transmitter ----------------
   assign tx_tick = (state == ST_SEND) && (tx_cnt == BIT_LAST);
   assign tx      = tx_shift[0];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         turn_cnt <= '0;
         tx_en    <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx_shift <= '1;
         tx_buf   <= '0;
      end else begin
         turn_cnt <= (state == ST_TURN) ? turn_cnt + TW'(1) : '0;
         if (state == ST_TURN && turn_cnt == TURN_EN) tx_en <= 1'b1;
         else if (state == ST_HOLD)                   tx_en <= 1'b0;
         if (accept) tx_buf <= {8'h5A, MY_ID, status, current_average, resp_chk};
         if (state == ST_TURN && turn_cnt == TURN_LAST) begin
            tx_shift <= {1'b1, tx_buf[63:56], 1'b0};
            tx_buf   <= {tx_buf[55:0], 8'h00};
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
         end else if (state == ST_SEND) begin
            if (!tx_tick) begin
               tx_cnt <= tx_cnt + CW'(1);
            end else begin
               tx_cnt <= '0;
               if (tx_bit != 4'd9) begin
                  tx_bit   <= tx_bit + 4'd1;
                  tx_shift <= {1'b1, tx_shift[9:1]};
               end else begin
                  tx_bit   <= '0;
                  tx_byte  <= tx_byte + 3'd1;
                  tx_shift <= (tx_byte == 3'd7) ? 10'h3FF : {1'b1, tx_buf[63:56], 1'b0};
                  tx_buf   <= {tx_buf[55:0], 8'h00};
               end
            end
         end else begin
            tx_shift <= '1;
         end
      end
   end

endmodule
